// File: rtl/vmx_systolic_engine_if.sv
// vmx_systolic_engine_if -- handshake/bus bundle for the systolic engine.
//   simd_mode           : lane mode sampled with each accepted vector
//   w_valid/w_ready/w_last, w_data : weight-row load channel (8 bits per column)
//   x_valid/x_ready/x_last, x_data : activation vector channel
//   y_valid/y_ready, y_data        : result channel (ACC_W bits per column)
//   busy                : engine not idle
// slave modport is used by the engine, master by whatever drives it.
interface vmx_systolic_engine_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2 * DATA_W
);
  logic                     simd_mode;
  logic                     w_valid;
  logic                     w_ready;
  logic                     w_last;
  logic [8*COLS-1:0]        w_data;
  logic                     x_valid;
  logic                     x_ready;
  logic                     x_last;
  logic [DATA_W*ROWS-1:0]   x_data;
  logic                     y_valid;
  logic                     y_ready;
  logic [ACC_W*COLS-1:0]    y_data;
  logic                     busy;

  modport slave (
    input  simd_mode, w_valid, w_last, w_data, x_valid, x_last, x_data, y_ready,
    output w_ready, x_ready, y_valid, y_data, busy
  );

  modport master (
    output simd_mode, w_valid, w_last, w_data, x_valid, x_last, x_data, y_ready,
    input  w_ready, x_ready, y_valid, y_data, busy
  );
endinterface

// File: rtl/vmx_systolic_engine.sv
// vmx_systolic_engine -- weight-stationary ROWSxCOLS systolic matrix-vector engine.
//   clk   : single clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of vmx_systolic_engine_if (weight load, vector in,
//           result out, simd_mode, busy)
// Activations flow left-to-right along rows, partial sums flow top-to-bottom
// along columns. Row r of each vector is delayed r cycles on entry and column c
// is delayed COLS-1-c cycles on exit so a whole result vector emerges at once,
// ROWS+COLS cycles after acceptance. A stalled output freezes the whole pipe.
module vmx_systolic_engine #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2 * DATA_W
) (
  input logic                 clk,
  input logic                 rst_n,
  vmx_systolic_engine_if.slave bus
);

  localparam int H     = DATA_W / 2;
  localparam int HA    = ACC_W / 2;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(ROWS + COLS + 1);
  localparam int DEPTH = ROWS + COLS;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t                state_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            w_q [ROWS][COLS];

  // element [DATA_W] carries the simd_mode bit of the vector beside its data
  logic [DATA_W:0]       sk_out [ROWS];
  logic [DATA_W:0]       xpass  [ROWS][COLS];
  logic [ACC_W-1:0]      psum   [ROWS][COLS];
  logic [ACC_W-1:0]      dsk_out [COLS];

  logic [DEPTH-1:0]      v_q;
  logic                  y_valid_q;
  logic [ACC_W*COLS-1:0] y_q, y_d;

  logic stall, adv, w_rdy, w_xfer, x_xfer, y_xfer;

  assign stall  = y_valid_q && !bus.y_ready;
  assign adv    = !stall;
  assign w_rdy  = (state_q == IDLE) || (state_q == LOAD);
  assign w_xfer = bus.w_valid && w_rdy;
  assign x_xfer = bus.x_valid && (state_q == RUN) && adv;
  assign y_xfer = y_valid_q && bus.y_ready;

  assign bus.w_ready = w_rdy;
  assign bus.x_ready = (state_q == RUN) && adv;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_q;
  assign bus.busy    = (state_q != IDLE);

  // Multiply-accumulate: full-width signed, or two independent half lanes
  // whose sums wrap within their own half of the accumulator.
  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] pin,
                                           input logic [DATA_W:0]  xin,
                                           input logic [7:0]       w);
    logic signed [ACC_W-1:0] full;
    logic signed [HA-1:0]    lo;
    logic signed [HA-1:0]    hi;
    full = ACC_W'($signed(xin[DATA_W-1:0])) * ACC_W'($signed(w));
    lo   = HA'($signed(xin[H-1:0]))         * HA'($signed(w));
    hi   = HA'($signed(xin[DATA_W-1:H]))    * HA'($signed(w));
    if (xin[DATA_W]) begin
      return {pin[ACC_W-1:HA] + hi, pin[HA-1:0] + lo};
    end
    return pin + full;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_comb begin
    cnt_d = cnt_q;
    if (x_xfer && !y_xfer) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!x_xfer && y_xfer) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        // A transfer accepted in IDLE is already weight row 0.
        IDLE, LOAD: begin
          if (w_xfer) begin
            if (bus.w_last || row_q == ROW_LAST) begin
              state_q <= RUN;
              row_q   <= '0;
            end else begin
              state_q <= LOAD;
              row_q   <= row_q + RW'(1);
            end
          end
        end
        RUN: begin
          if (x_xfer && bus.x_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_d == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ weights
  // An early w_last zero-fills every row below the one being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else if (w_xfer) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (RW'(r) == row_q) begin
            w_q[r][c] <= bus.w_data[8*c +: 8];
          end else if (bus.w_last && RW'(r) > row_q) begin
            w_q[r][c] <= '0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------- input skew
  // Row r passes through r+1 registers; empty cycles inject zeros so that
  // bubbles contribute nothing to any sum.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W:0] sk_q [r+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k <= r; k++) begin
          sk_q[k] <= '0;
        end
      end else if (adv) begin
        sk_q[0] <= x_xfer ? {bus.simd_mode, bus.x_data[DATA_W*r +: DATA_W]} : '0;
        for (int unsigned k = 1; k <= r; k++) begin
          sk_q[k] <= sk_q[k-1];
        end
      end
    end
    assign sk_out[r] = sk_q[r];
  end

  // ---------------------------------------------------------- PE array
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_W:0]  xin;
      logic [ACC_W-1:0] pin;
      logic [ACC_W-1:0] p_q;

      if (c == 0) begin : g_xl
        assign xin = sk_out[r];
      end else begin : g_xr
        assign xin = xpass[r][c-1];
      end

      if (r == 0) begin : g_pt
        assign pin = '0;
      end else begin : g_pd
        assign pin = psum[r-1][c];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p_q <= '0;
        end else if (adv) begin
          p_q <= mac(pin, xin, w_q[r][c]);
        end
      end
      assign psum[r][c] = p_q;

      if (c < COLS - 1) begin : g_xreg
        logic [DATA_W:0] x_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            x_q <= '0;
          end else if (adv) begin
            x_q <= xin;
          end
        end
        assign xpass[r][c] = x_q;
      end else begin : g_xend
        assign xpass[r][c] = '0;
      end
    end
  end

  // ------------------------------------------------------ output deskew
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D > 0) begin : g_chain
      logic [ACC_W-1:0] ds_q [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < D; k++) begin
            ds_q[k] <= '0;
          end
        end else if (adv) begin
          ds_q[0] <= psum[ROWS-1][c];
          for (int unsigned k = 1; k < D; k++) begin
            ds_q[k] <= ds_q[k-1];
          end
        end
      end
      assign dsk_out[c] = ds_q[D-1];
    end else begin : g_pass
      assign dsk_out[c] = psum[ROWS-1][c];
    end
  end

  always_comb begin
    y_d = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      y_d[ACC_W*c +: ACC_W] = dsk_out[c];
    end
  end

  // Valid tags shadow the data through skew, array and deskew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
    end else if (adv) begin
      v_q       <= {v_q[DEPTH-2:0], x_xfer};
      y_valid_q <= v_q[DEPTH-1];
      y_q       <= y_d;
    end
  end

endmodule
